sa_rr_alloc: RTL
================

SA_RR_ALLOC -- requirements
Module: sa_rr_alloc

Interface
REQ-001 SHALL have parameter NUM_VC, default 2, meaning the number of virtual-channel inputs (2..8).
REQ-002 SHALL have parameter FLIT_W, default 32, meaning the flit width in bits.
REQ-003 SHALL have parameter GATE_W, default 3, meaning the output-port select width.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port vc_flit  input  NUM_VC*FLIT_W  per-VC flit; VC i occupies bits [i*FLIT_W +: FLIT_W].
REQ-007 SHALL have port vc_gate  input  NUM_VC*GATE_W  per-VC routed output port.
REQ-008 SHALL have port vc_type  input  NUM_VC*2  per-VC flit type: 00 = none, 01 = head, 10 = body, 11 = tail.
REQ-009 SHALL have port vc_grant  output  NUM_VC  one-hot pop; VC i's flit is consumed in this cycle.
REQ-010 SHALL have port sa_flit  output  FLIT_W  registered winning flit.
REQ-011 SHALL have port sa_gate  output  GATE_W  registered winning gate.
REQ-012 SHALL have port sa_type  output  2  registered winning type.
REQ-013 SHALL have port sa_valid  output  1  output register holds a flit.
REQ-014 SHALL have port sa_ready  input  1  downstream accepts the flit when sa_valid and sa_ready are both high.
REQ-015 SHALL have port sa_err  output  1  sticky protocol-error flag.

Function
REQ-016 Load enable: ld = !sa_valid || sa_ready. No grant is issued when ld = 0; the output register holds its value.
REQ-017 vc_grant SHALL be combinational, at most one bit high, and SHALL be all-zero while reset = 1.
REQ-018 Unlocked state: eligible VCs are those with type = 01. The winner is the first eligible VC found searching from rr_ptr upward, modulo NUM_VC.
REQ-019 On a head grant: lock = 1, lock_vc = winner, and rr_ptr = (winner+1) mod NUM_VC.
REQ-020 Locked state: only lock_vc is eligible, and only with type 10 or 11.
- Type 00 on lock_vc: no grant; lock is held (bubble).
REQ-021 A granted tail (11) in the locked state SHALL clear lock on the same edge. rr_ptr is unchanged.
REQ-022 On grant with ld = 1, the next edge SHALL load sa_flit, sa_gate and sa_type from the winner and set sa_valid = 1. Latency from grant to sa_valid is exactly 1 cycle.
REQ-023 With ld = 1 and no grant, the next edge SHALL set sa_valid = 0. sa_flit, sa_gate and sa_type hold their values.
REQ-024 Simultaneous accept and new grant SHALL sustain 1 flit per cycle with no bubble.
REQ-025 sa_err SHALL be set (sticky until reset) in either case:
- unlocked, and any VC presents type 10 or 11;
- locked, and lock_vc presents type 01.
The offending flit SHALL NOT be granted.
REQ-026 Non-locked VCs presenting heads while locked SHALL wait; no grant and no error.
REQ-027 rr_ptr SHALL be ceil(log2(NUM_VC)) bits wide and SHALL wrap from NUM_VC-1 to 0.

Reset
REQ-028 While reset = 1 at a rising edge, the following SHALL be forced:
- sa_valid = 0, sa_flit = 0, sa_gate = 0, sa_type = 00;
- lock = 0, lock_vc = 0, rr_ptr = 0;
- sa_err = 0.
REQ-029 Reset asserted mid-packet SHALL abandon the lock. The first cycle after reset is in the unlocked state.

Verification
REQ-030 NUM_VC = 2; both VCs present a head (flit A on VC0, B on VC1) after reset; sa_ready = 1 -> vc_grant = 01; next cycle sa_flit = A, sa_valid = 1; rr_ptr = 1.
REQ-031 VC0 sends head/body/tail over 3 cycles while VC1 holds a head -> vc_grant = 01 for 3 cycles, then 10 in cycle 4; sa_type sequence 01, 10, 11, 01.
REQ-032 Locked VC0 inserts a type-00 bubble between body and tail -> no grant in that cycle; sa_valid = 0 for 1 cycle; lock held; tail then granted.
REQ-033 sa_valid = 1 with sa_ready = 0 for 3 cycles -> vc_grant = 0 and sa_flit stable; sa_ready = 1 -> the pending head is granted the same cycle.
REQ-034 Unlocked, VC1 presents body 10 -> sa_err = 1 next edge and stays set; vc_grant = 0; reset -> sa_err = 0.
REQ-035 NUM_VC = 4, all VCs present repeated single head+tail packets -> grant order VC0, VC1, VC2, VC3, VC0, with rr_ptr wrapping from 3 to 0.

Source files
------------

// File: rtl/sa_rr_alloc.sv
// Round-robin switch allocator with wormhole packet locking and a one-deep registered output stage.
// Latency: 1 cycle from grant to sa_valid. Backpressure: no grant is issued while sa_valid && !sa_ready.
module sa_rr_alloc #(
  parameter int NUM_VC = 2,
  parameter int FLIT_W = 32,
  parameter int GATE_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_VC*FLIT_W-1:0]   vc_flit,
  input  logic [NUM_VC*GATE_W-1:0]   vc_gate,
  input  logic [NUM_VC*2-1:0]        vc_type,
  output logic [NUM_VC-1:0]          vc_grant,
  output logic [FLIT_W-1:0]          sa_flit,
  output logic [GATE_W-1:0]          sa_gate,
  output logic [1:0]                 sa_type,
  output logic                       sa_valid,
  input  logic                       sa_ready,
  output logic                       sa_err
);

  localparam int PTR_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam logic [PTR_W-1:0] LAST_VC = PTR_W'(NUM_VC - 1);

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic              ld;
  logic              lock;
  logic [PTR_W-1:0]  lock_vc;
  logic [PTR_W-1:0]  rr_ptr;
  logic [1:0]        lock_type;
  logic              win_vld;
  logic [PTR_W-1:0]  win_idx;
  logic              err_now;
  logic              gnt;
  logic [FLIT_W-1:0] win_flit;
  logic [GATE_W-1:0] win_gate;
  logic [1:0]        win_type;

  function automatic int wrap_idx(input int base, input int ofs);
    return (base + ofs) % NUM_VC;
  endfunction

  assign ld        = !sa_valid || sa_ready;
  assign lock_type = vc_type[int'(lock_vc)*2 +: 2];

  // Body/tail types carry bit 1; they are only legal from the locked VC.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    err_now = 1'b0;
    if (lock) begin
      if (lock_type[1]) begin
        win_vld = 1'b1;
        win_idx = lock_vc;
      end
      err_now = (lock_type == T_HEAD);
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (vc_type[2*i+1]) err_now = 1'b1;
        if (!win_vld && vc_type[2*wrap_idx(int'(rr_ptr), i) +: 2] == T_HEAD) begin
          win_vld = 1'b1;
          win_idx = PTR_W'(wrap_idx(int'(rr_ptr), i));
        end
      end
    end
  end

  assign gnt      = win_vld && ld && !reset;
  assign win_flit = vc_flit[int'(win_idx)*FLIT_W +: FLIT_W];
  assign win_gate = vc_gate[int'(win_idx)*GATE_W +: GATE_W];
  assign win_type = vc_type[int'(win_idx)*2 +: 2];

  always_comb begin
    vc_grant = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      vc_grant[i] = gnt && (int'(win_idx) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa_valid <= 1'b0;
      sa_flit  <= '0;
      sa_gate  <= '0;
      sa_type  <= 2'b00;
      lock     <= 1'b0;
      lock_vc  <= '0;
      rr_ptr   <= '0;
      sa_err   <= 1'b0;
    end else begin
      if (err_now) sa_err <= 1'b1;

      if (ld) begin
        sa_valid <= gnt;
        if (gnt) begin
          sa_flit <= win_flit;
          sa_gate <= win_gate;
          sa_type <= win_type;
        end
      end

      // Pointer advances only on heads so a packet's body never moves fairness.
      if (gnt) begin
        if (!lock) begin
          lock    <= 1'b1;
          lock_vc <= win_idx;
          rr_ptr  <= (win_idx == LAST_VC) ? '0 : win_idx + PTR_W'(1);
        end else if (win_type == T_TAIL) begin
          lock <= 1'b0;
        end
      end
    end
  end

endmodule
